// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution sequencer.
// Holds the sequencer state enumeration and the pixel/result/window sizes
// used by conv_sequencer and conv_win_addr.
package conv_pkg;

  localparam int PIXEL_W  = 7;
  localparam int RESULT_W = 19;
  localparam int WIN      = 3;
  localparam int TAPS     = WIN * WIN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/conv_win_addr.sv
// Window read-address generator.
// Maps (window row r, window column c, tap index 0..8) to the input-memory
// address (r+i)*IMG_W + (c+j), with i = tap/3 (outer) and j = tap%3 (inner).
// Ports:
//   r_i, c_i   window origin (row, column)
//   tap_i      tap index within the 3x3 window
//   addr_o     input-memory address for that tap
module conv_win_addr #(
  parameter int IMG_W  = 8,
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] r_i,
  input  logic [ADDR_W-1:0] c_i,
  input  logic [3:0]        tap_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [1:0]  row_off;
  logic [1:0]  col_off;
  logic [31:0] addr_full;

  always_comb begin
    row_off = '0;
    col_off = '0;
    case (tap_i)
      4'd0: begin row_off = 2'd0; col_off = 2'd0; end
      4'd1: begin row_off = 2'd0; col_off = 2'd1; end
      4'd2: begin row_off = 2'd0; col_off = 2'd2; end
      4'd3: begin row_off = 2'd1; col_off = 2'd0; end
      4'd4: begin row_off = 2'd1; col_off = 2'd1; end
      4'd5: begin row_off = 2'd1; col_off = 2'd2; end
      4'd6: begin row_off = 2'd2; col_off = 2'd0; end
      4'd7: begin row_off = 2'd2; col_off = 2'd1; end
      4'd8: begin row_off = 2'd2; col_off = 2'd2; end
      default: begin row_off = 2'd0; col_off = 2'd0; end
    endcase
    addr_full = (32'(r_i) + 32'(row_off)) * 32'(IMG_W) + 32'(c_i) + 32'(col_off);
    addr_o    = addr_full[ADDR_W-1:0];
  end

endmodule

// File: rtl/conv_sequencer.sv
// 3x3 convolution sequencer.
// Walks every 3x3 window of an IMG_W x IMG_H input image in row-major order:
// clears the convolver, feeds it nine pixels from input memory, waits for the
// convolver result and writes it to output memory at r*(IMG_W-2)+c.
// Ports:
//   clk100, in_reset         clock, asynchronous active-low reset
//   i_start, i_abort         start one pass / abort current pass
//   o_busy, o_done           pass in progress / one-cycle completion pulse
//   o_rd_en, o_rd_addr       input-memory read (data one cycle later)
//   i_rd_data                input pixel
//   o_conv_clr, o_conv_pix   convolver clear and pixel
//   i_conv_res               convolver result
//   o_wr_en/addr/data        output-memory write
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 6,
  parameter int CAP_DLY = 3
) (
  input  logic                clk100,
  input  logic                in_reset,
  input  logic                i_start,
  input  logic                i_abort,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_rd_en,
  output logic [ADDR_W-1:0]   o_rd_addr,
  input  logic [PIXEL_W-1:0]  i_rd_data,
  output logic                o_conv_clr,
  output logic [PIXEL_W-1:0]  o_conv_pix,
  input  logic [RESULT_W-1:0] i_conv_res,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [RESULT_W-1:0] o_wr_data
);

  localparam bit DEGEN    = (IMG_W < WIN) || (IMG_H < WIN);
  localparam int LAST_C   = DEGEN ? 0 : IMG_W - WIN;
  localparam int LAST_R   = DEGEN ? 0 : IMG_H - WIN;
  localparam int OUT_W    = DEGEN ? 1 : IMG_W - 2;
  localparam int LAST_TAP = TAPS - 1;
  localparam int DW       = $clog2(CAP_DLY + 1) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] r_q, r_d, c_q, c_d;
  logic [3:0]        tap_q, tap_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       wr_addr_full;

  logic              busy_q, done_q, rd_en_q, clr_q, pix_vld_q, wr_en_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;

  conv_win_addr #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .r_i    (r_d),
    .c_i    (c_d),
    .tap_i  (tap_d),
    .addr_o (win_addr)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    tap_d   = tap_q;
    dly_d   = dly_q;
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      r_d     = '0;
      c_d     = '0;
      tap_d   = '0;
      dly_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_d     = '0;
            c_d     = '0;
            tap_d   = '0;
            dly_d   = '0;
            state_d = DEGEN ? S_DONE : S_CLR;
          end
        end
        S_CLR: begin
          tap_d   = '0;
          state_d = S_FEED;
        end
        S_FEED: begin
          if (tap_q == 4'(LAST_TAP)) begin
            dly_d   = '0;
            state_d = S_WAIT;
          end else begin
            tap_d = tap_q + 4'd1;
          end
        end
        // WAIT spans the pixel-lag cycle (ninth pixel presented) plus
        // CAP_DLY capture cycles, hence the count runs 0..CAP_DLY.
        S_WAIT: begin
          if (dly_q == DW'(CAP_DLY)) begin
            state_d = S_WRITE;
          end else begin
            dly_d = dly_q + DW'(1);
          end
        end
        S_WRITE: begin
          if (c_q == ADDR_W'(LAST_C)) begin
            c_d = '0;
            if (r_q == ADDR_W'(LAST_R)) begin
              state_d = S_DONE;
            end else begin
              r_d     = r_q + ADDR_W'(1);
              state_d = S_CLR;
            end
          end else begin
            c_d     = c_q + ADDR_W'(1);
            state_d = S_CLR;
          end
        end
        S_DONE: begin
          r_d     = '0;
          c_d     = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    wr_addr_full = 32'(r_d) * 32'(OUT_W) + 32'(c_d);
  end

  always_ff @(posedge clk100 or negedge in_reset) begin
    if (!in_reset) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      tap_q     <= '0;
      dly_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      clr_q     <= 1'b0;
      pix_vld_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      tap_q     <= tap_d;
      dly_q     <= dly_d;
      busy_q    <= state_d inside {S_CLR, S_FEED, S_WAIT, S_WRITE};
      done_q    <= (state_d == S_DONE);
      rd_en_q   <= (state_d == S_FEED);
      rd_addr_q <= (state_d == S_FEED) ? win_addr : '0;
      clr_q     <= (state_d == S_CLR);
      pix_vld_q <= rd_en_q && (state_d != S_IDLE);
      wr_en_q   <= (state_d == S_WRITE);
      wr_addr_q <= (state_d == S_WRITE) ? wr_addr_full[ADDR_W-1:0] : '0;
    end
  end

  // Clear is forced high while reset is held, but the register itself resets
  // low so the first cycle after release is a clean IDLE with clear low.
  assign o_conv_clr = clr_q | ~in_reset;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rd_en    = rd_en_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_conv_pix = pix_vld_q ? i_rd_data : '0;
  // An abort arriving in the WRITE cycle itself must still kill that write.
  assign o_wr_en    = wr_en_q & ~i_abort;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = o_wr_en ? i_conv_res : '0;

endmodule

// File: tb/tb_conv_sequencer.sv
module tb_conv_sequencer;

  localparam int W    = 5;
  localparam int H    = 5;
  localparam int AW   = 6;
  localparam int CD   = 3;
  localparam int P    = 12 + CD;
  localparam int NWIN = (W - 2) * (H - 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort;
  logic          busy, done, rd_en, conv_clr, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [6:0]    rd_data, conv_pix;
  logic [18:0]   conv_res, wr_data, acc;

  logic          d_start, d_abort;
  logic          d_busy, d_done, d_rd_en, d_conv_clr, d_wr_en;
  logic [AW-1:0] d_rd_addr, d_wr_addr;
  logic [6:0]    d_rd_data, d_conv_pix;
  logic [18:0]   d_conv_res, d_wr_data;

  conv_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CAP_DLY(CD)) u_dut (
    .clk100(clk), .in_reset(rst_n), .i_start(start), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
    .i_rd_data(rd_data), .o_conv_clr(conv_clr), .o_conv_pix(conv_pix),
    .i_conv_res(conv_res), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data)
  );

  conv_sequencer #(.IMG_W(2), .IMG_H(4), .ADDR_W(AW), .CAP_DLY(CD)) u_deg (
    .clk100(clk), .in_reset(rst_n), .i_start(d_start), .i_abort(d_abort),
    .o_busy(d_busy), .o_done(d_done), .o_rd_en(d_rd_en), .o_rd_addr(d_rd_addr),
    .i_rd_data(d_rd_data), .o_conv_clr(d_conv_clr), .o_conv_pix(d_conv_pix),
    .i_conv_res(d_conv_res), .o_wr_en(d_wr_en), .o_wr_addr(d_wr_addr),
    .o_wr_data(d_wr_data)
  );

  // Input memory (1-cycle read latency) and an all-ones-kernel convolver.
  logic [6:0] mem [0:63];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  always @(posedge clk) begin
    if (conv_clr) acc <= '0;
    else          acc <= acc + 19'(conv_pix);
  end
  assign conv_res = acc;

  int n_chk = 0, n_pass = 0;
  int mt = 0;
  int wr_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int d_rd_cnt = 0, d_wr_cnt = 0, d_busy_cnt = 0;
  int wr_seen [0:63];
  int rd_q [$];
  bit saw_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
  endtask

  function automatic int tap_addr(input int w, input int k);
    int r, c;
    r = w / (W - 2);
    c = w % (W - 2);
    return (r + k / 3) * W + c + k % 3;
  endfunction

  function automatic int win_sum(input int w);
    int s = 0;
    for (int k = 0; k < 9; k++) s += int'(mem[tap_addr(w, k)]);
    return s;
  endfunction

  // Per-cycle comparison against the pass timeline: cycle mt of a pass falls
  // in window (mt-1)/P at phase (mt-1)%P; phase 0 clear, 1..9 reads,
  // 2..10 pixels, P-1 write; done one cycle after the last window.
  task automatic cmp_cycle();
    int ph, w;
    int e_busy, e_done, e_rd, e_clr, e_pix, e_wr, e_rda, e_wra, e_wrd;
    if (wr_en) begin wr_cnt++; wr_seen[int'(wr_addr)] = int'(wr_data); end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (rd_en) rd_q.push_back(int'(rd_addr));
    if (d_rd_en) d_rd_cnt++;
    if (d_wr_en) d_wr_cnt++;
    if (d_busy) d_busy_cnt++;
    saw_done = (done === 1'b1);
    e_busy = 0; e_done = 0; e_rd = 0; e_clr = 0; e_pix = 0; e_wr = 0;
    e_rda = -1; e_wra = -1; e_wrd = 0;
    if (!rst_n) begin
      e_clr = 1; e_rda = 0; e_wra = 0;
    end else if (mt == NWIN * P + 1) begin
      e_done = 1;
    end else if (mt != 0) begin
      ph = (mt - 1) % P;
      w  = (mt - 1) / P;
      e_busy = 1;
      e_clr  = (ph == 0) ? 1 : 0;
      if (ph >= 1 && ph <= 9) begin e_rd = 1; e_rda = tap_addr(w, ph - 1); end
      if (ph >= 2 && ph <= 10) e_pix = int'(mem[tap_addr(w, ph - 2)]);
      if (ph == P - 1 && !abort) begin e_wr = 1; e_wra = w; e_wrd = win_sum(w); end
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("conv_clr", 32'(conv_clr), 32'(e_clr));
    chk("conv_pix", 32'(conv_pix), 32'(e_pix));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("wr_data", 32'(wr_data), 32'(e_wrd));
    if (e_rda >= 0) chk("rd_addr", 32'(rd_addr), 32'(e_rda));
    if (e_wra >= 0) chk("wr_addr", 32'(wr_addr), 32'(e_wra));
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    if (!rst_n) mt = 0;
    else if (mt != 0) begin
      if (abort || mt == NWIN * P + 1) mt = 0;
      else mt++;
    end else if (start && !abort) mt = 1;
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (saw_done) begin got = 1; break; end
    end
    chk("done_timeout", 32'(got), 32'd1);
    tick();
  endtask

  initial begin
    int b_wr, b_done, b_busy, b_rd;
    int exp_rd [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    d_start = 1'b0; d_abort = 1'b0; d_rd_data = '0; d_conv_res = '0;
    acc = '0; rd_data = '0;
    for (int a = 0; a < 64; a++) begin mem[a] = 7'(a); wr_seen[a] = -1; end
    @(posedge clk); #1;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clr", 32'(conv_clr), 32'd1);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_clr", 32'(conv_clr), 32'd0);

    // Ramp image: pixel value equals its address.
    b_wr = wr_cnt; b_done = done_cnt; b_busy = busy_cnt; b_rd = rd_q.size();
    start_pulse();
    wait_done();
    chk("ramp_writes", 32'(wr_cnt - b_wr), 32'd9);
    chk("ramp_dones", 32'(done_cnt - b_done), 32'd1);
    chk("ramp_busy_cycles", 32'(busy_cnt - b_busy), 32'd135);
    for (int k = 0; k < 9; k++) chk("ramp_first_reads", 32'(rd_q[b_rd + k]), 32'(exp_rd[k]));
    chk("ramp_w0", 32'(wr_seen[0]), 32'd54);
    chk("ramp_w8", 32'(wr_seen[8]), 32'd162);

    // All-ones image: every window sums to 9.
    for (int a = 0; a < 64; a++) mem[a] = 7'd1;
    b_wr = wr_cnt; b_done = done_cnt;
    start_pulse();
    wait_done();
    chk("ones_writes", 32'(wr_cnt - b_wr), 32'd9);
    chk("ones_dones", 32'(done_cnt - b_done), 32'd1);
    for (int a = 0; a < 9; a++) chk("ones_value", 32'(wr_seen[a]), 32'd9);

    // Start re-pulsed during FEED is ignored.
    for (int a = 0; a < 64; a++) mem[a] = 7'(a);
    b_wr = wr_cnt; b_done = done_cnt;
    start_pulse();
    tick(); tick();
    start_pulse();
    wait_done();
    chk("restart_writes", 32'(wr_cnt - b_wr), 32'd9);
    chk("restart_dones", 32'(done_cnt - b_done), 32'd1);

    // Abort in the WRITE cycle of window 2, then a fresh pass.
    b_wr = wr_cnt; b_done = done_cnt;
    start_pulse();
    repeat (44) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    chk("abort_writes", 32'(wr_cnt - b_wr), 32'd2);
    chk("abort_dones", 32'(done_cnt - b_done), 32'd0);
    b_wr = wr_cnt; b_done = done_cnt; b_rd = rd_q.size();
    start_pulse();
    wait_done();
    chk("reabort_writes", 32'(wr_cnt - b_wr), 32'd9);
    chk("reabort_dones", 32'(done_cnt - b_done), 32'd1);
    chk("reabort_rd0", 32'(rd_q[b_rd]), 32'd0);
    chk("reabort_rd8", 32'(rd_q[b_rd + 8]), 32'd12);

    // Abort and start together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    tick();

    // Asynchronous reset in the middle of FEED.
    start_pulse();
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_en", 32'(rd_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_clr", 32'(conv_clr), 32'd1);
    chk("arst_pix", 32'(conv_pix), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'd0);
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    b_wr = wr_cnt; b_done = done_cnt;
    start_pulse();
    wait_done();
    chk("postrst_writes", 32'(wr_cnt - b_wr), 32'd9);
    chk("postrst_dones", 32'(done_cnt - b_done), 32'd1);
    chk("postrst_w0", 32'(wr_seen[0]), 32'd54);

    // Degenerate 2-wide image: straight to DONE, no memory traffic.
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    chk("deg_done", 32'(d_done), 32'd1);
    chk("deg_busy", 32'(d_busy), 32'd0);
    tick();
    chk("deg_done_pulse", 32'(d_done), 32'd0);
    repeat (4) tick();
    chk("deg_reads", 32'(d_rd_cnt), 32'd0);
    chk("deg_writes", 32'(d_wr_cnt), 32'd0);
    chk("deg_busy_cycles", 32'(d_busy_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels.
REQ-002 Parameter IMG_H, default 8, image height in pixels.
REQ-003 Parameter ADDR_W, default 6, address width of input and output image memories.
REQ-004 Parameter CAP_DLY, default 3, cycles from ninth window pixel to convolver result capture.
REQ-005 clk100  in  1  single clock; all logic on its rising edge.
REQ-006 in_reset  in  1  asynchronous, active-low reset.
REQ-007 i_start  in  1  one-cycle pulse; starts one full-image pass.
REQ-008 i_abort  in  1  synchronous abort of the current pass.
REQ-009 o_busy  out  1  high from accepted start until DONE or abort.
REQ-010 o_done  out  1  one-cycle pulse at pass completion.
REQ-011 o_rd_en / o_rd_addr  out  1 / ADDR_W  input-memory read; data returns 1 cycle later.
REQ-012 i_rd_data  in  7  input pixel from memory.
REQ-013 o_conv_clr  out  1  active-high synchronous clear to the 3x3 convolver.
REQ-014 o_conv_pix  out  7  pixel presented to convolver i_pixel.
REQ-015 i_conv_res  in  19  convolver o_pixel.
REQ-016 o_wr_en / o_wr_addr / o_wr_data  out  1 / ADDR_W / 19  output-memory write port.

Function
REQ-017 Output image SHALL be (IMG_W-2) x (IMG_H-2), one write per window, row-major; window (r,c) written to address r*(IMG_W-2)+c.
REQ-018 States SHALL be IDLE, CLR, FEED, WAIT, WRITE, DONE.
REQ-019 IDLE -> CLR on i_start; i_start while busy SHALL be ignored.
REQ-020 CLR: o_conv_clr high for exactly 1 cycle, then FEED.
REQ-021 FEED: 9 consecutive cycles of o_rd_en, addresses (r+i)*IMG_W+(c+j), i outer 0..2, j inner 0..2; no gaps.
REQ-022 o_conv_pix SHALL equal i_rd_data registered-through, i.e. valid the cycle after each read; zero otherwise.
REQ-023 WAIT: CAP_DLY cycles counted from the cycle the ninth pixel is presented; then WRITE.
REQ-024 WRITE: 1 cycle, o_wr_en high, o_wr_data = i_conv_res sampled that cycle.
REQ-025 After WRITE: c increments; at c = IMG_W-3, c wraps to 0 and r increments; after last window (IMG_H-3, IMG_W-3) -> DONE, else -> CLR.
REQ-026 DONE: o_done high 1 cycle, o_busy low same cycle, -> IDLE.
REQ-027 IMG_W < 3 or IMG_H < 3: start SHALL go straight to DONE with no reads or writes.
REQ-028 i_abort in any non-IDLE state: next cycle IDLE, o_busy low, no o_done, no further write; abort in WRITE cycle suppresses that write.
REQ-029 i_abort and i_start together in IDLE: abort wins, start ignored.
REQ-030 o_rd_en, o_wr_en, o_conv_clr SHALL be low outside their states.
REQ-031 Throughput: exactly 11+CAP_DLY+1 cycles per window (CLR 1, FEED 9, pixel lag 1, WAIT CAP_DLY, WRITE 1), with CLR of the next window not overlapping WRITE.

Reset
REQ-032 in_reset low SHALL asynchronously force IDLE, r=c=0, all counters 0.
REQ-033 Reset values: o_busy 0, o_done 0, o_rd_en 0, o_rd_addr 0, o_conv_clr 1, o_conv_pix 0, o_wr_en 0, o_wr_addr 0, o_wr_data 0.
REQ-034 Reset mid-pass SHALL discard the pass; first cycle after release is IDLE with o_conv_clr 0.

Structure
REQ-035 Shared package conv_pkg SHALL hold the state enumeration, PIXEL_W=7, RESULT_W=19 and window size 3.
REQ-036 Sub-module conv_win_addr SHALL generate read addresses from (r, c, tap index); all other logic in conv_sequencer.

Verification
REQ-037 4x4 all-ones image, all-ones kernel convolver: 4 writes to addr 0..3, each 9, one o_done, o_busy high throughout.
REQ-038 5x5 ramp pixel=addr: first window reads 0,1,2,5,6,7,10,11,12; written value 54 at addr 0; 9 writes total.
REQ-039 i_start re-pulsed during FEED: no restart, write count unchanged, single o_done.
REQ-040 i_abort during the WRITE cycle of window 2: that write absent, o_busy low next cycle, no o_done; subsequent start restarts at window 0.
REQ-041 in_reset asserted mid-FEED: outputs at reset values immediately (asynchronous), o_conv_clr 1; after release, new start produces full correct pass.
REQ-042 IMG_W=2: start yields o_done the cycle after CLR-less transition, zero reads, zero writes.
